// File: rtl/pipe_stage_reg_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : pipe_stage_reg_if
// Description : Bundle between a pipeline stage and pipe_stage_reg: hazard
//               controls, the incoming instruction fields, the outgoing
//               last-stage fields and the performance counters.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
interface pipe_stage_reg_if #(
  parameter int CTRL_W = 2,
  parameter int DATA_W = 69,
  parameter int CNT_W  = 16
);
  logic              stall;
  logic              flush;
  logic              in_valid;
  logic [CTRL_W-1:0] ctrl_in;
  logic [DATA_W-1:0] data_in;
  logic              out_valid;
  logic [CTRL_W-1:0] ctrl_out;
  logic [DATA_W-1:0] data_out;
  logic [CNT_W-1:0]  retire_cnt;
  logic [CNT_W-1:0]  stall_cnt;

  // Upstream stage / hazard unit side
  modport master (
    output stall, flush, in_valid, ctrl_in, data_in,
    input  out_valid, ctrl_out, data_out, retire_cnt, stall_cnt
  );

  // Register block side
  modport slave (
    input  stall, flush, in_valid, ctrl_in, data_in,
    output out_valid, ctrl_out, data_out, retire_cnt, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : pipe_stage_reg
// Description : Parametrised inter-stage pipeline register chain (DEPTH
//               stages, legal 1..8) with stall hold, flush bubble injection,
//               per-stage valid bit and retire/stall performance counters.
//               Priority per cycle: rst > flush > stall > advance.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int CTRL_W = 2,
  parameter int DATA_W = 69,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = 16
) (
  input  wire logic         clk,
  input  wire logic         rst,
  pipe_stage_reg_if.slave   bus
);

  localparam int c_LAST = DEPTH - 1;

  logic              r_valid [DEPTH];
  logic [CTRL_W-1:0] r_ctrl  [DEPTH];
  logic [DATA_W-1:0] r_data  [DEPTH];

  // Value each stage would load on an advance edge
  logic              w_src_valid [DEPTH];
  logic [CTRL_W-1:0] w_src_ctrl  [DEPTH];
  logic [DATA_W-1:0] w_src_data  [DEPTH];

  logic [CNT_W-1:0]  r_retire_cnt;
  logic [CNT_W-1:0]  r_stall_cnt;

  // The last-stage instruction leaves on an advance edge, and is also treated
  // as consumed downstream on a flush edge.
  logic w_retire;
  assign w_retire = r_valid[c_LAST] && (bus.flush || !bus.stall);

  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      if (k == 0) begin : g_head
        // Control is gated here so a bubble never carries live control bits
        assign w_src_valid[k] = bus.in_valid;
        assign w_src_ctrl[k]  = bus.in_valid ? bus.ctrl_in : '0;
        assign w_src_data[k]  = bus.data_in;
      end else begin : g_body
        assign w_src_valid[k] = r_valid[k-1];
        assign w_src_ctrl[k]  = r_ctrl[k-1];
        assign w_src_data[k]  = r_data[k-1];
      end

      // Stage k: clear on reset, bubble on flush (data kept), hold on stall
      always_ff @(posedge clk) begin
        if (rst) begin
          r_valid[k] <= 1'b0;
          r_ctrl[k]  <= '0;
          r_data[k]  <= '0;
        end else if (bus.flush) begin
          r_valid[k] <= 1'b0;
          r_ctrl[k]  <= '0;
        end else if (!bus.stall) begin
          r_valid[k] <= w_src_valid[k];
          r_ctrl[k]  <= w_src_ctrl[k];
          r_data[k]  <= w_src_data[k];
        end
      end
    end
  endgenerate

  // Performance counters, free-running and wrapping modulo 2^CNT_W
  always_ff @(posedge clk) begin
    if (rst) begin
      r_retire_cnt <= '0;
      r_stall_cnt  <= '0;
    end else begin
      if (w_retire) begin
        r_retire_cnt <= r_retire_cnt + CNT_W'(1);
      end
      if (bus.stall && !bus.flush) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.out_valid  = r_valid[c_LAST];
  assign bus.ctrl_out   = r_ctrl[c_LAST];
  assign bus.data_out   = r_data[c_LAST];
  assign bus.retire_cnt = r_retire_cnt;
  assign bus.stall_cnt  = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : tb_pipe_stage_reg
// Description : Directed self-checking bench for pipe_stage_reg; three
//               instances (DEPTH=3, DEPTH=1, DEPTH=1 with 4-bit counters).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.CTRL_W(2), .DATA_W(8), .CNT_W(16)) b3 ();
  pipe_stage_reg_if #(.CTRL_W(2), .DATA_W(8), .CNT_W(16)) b1 ();
  pipe_stage_reg_if #(.CTRL_W(2), .DATA_W(8), .CNT_W(4))  bw ();

  pipe_stage_reg #(.CTRL_W(2), .DATA_W(8), .DEPTH(3), .CNT_W(16)) u3 (
    .clk(clk), .rst(rst), .bus(b3.slave));
  pipe_stage_reg #(.CTRL_W(2), .DATA_W(8), .DEPTH(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .bus(b1.slave));
  pipe_stage_reg #(.CTRL_W(2), .DATA_W(8), .DEPTH(1), .CNT_W(4))  uw (
    .clk(clk), .rst(rst), .bus(bw.slave));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  initial begin
    // Reset with live-looking inputs on every instance
    rst = 1'b1;
    b3.stall = 0; b3.flush = 0; b3.in_valid = 1; b3.ctrl_in = 2'b11; b3.data_in = 8'hFF;
    b1.stall = 0; b1.flush = 0; b1.in_valid = 1; b1.ctrl_in = 2'b11; b1.data_in = 8'hFF;
    bw.stall = 0; bw.flush = 0; bw.in_valid = 1; bw.ctrl_in = 2'b11; bw.data_in = 8'hFF;
    step();
    step();
    rst = 1'b0;
    b3.in_valid = 0; b3.ctrl_in = 0; b3.data_in = 0;
    b1.in_valid = 0; b1.ctrl_in = 0; b1.data_in = 0;
    bw.in_valid = 0; bw.ctrl_in = 0; bw.data_in = 0;
    step();
    chk("rst_out_valid", 64'(b3.out_valid), 64'd0);
    chk("rst_ctrl_out", 64'(b3.ctrl_out), 64'd0);
    chk("rst_data_out", 64'(b3.data_out), 64'd0);
    chk("rst_retire", 64'(b3.retire_cnt), 64'd0);
    chk("rst_stall", 64'(b3.stall_cnt), 64'd0);
    chk("rst_d1_valid", 64'(b1.out_valid), 64'd0);
    chk("rst_d1_data", 64'(b1.data_out), 64'd0);

    // Streaming on DEPTH=3: values 1..4 emerge after edges 3..6
    for (int j = 1; j <= 7; j++) begin
      b3.in_valid = (j <= 4);
      b3.ctrl_in  = (j <= 4) ? 2'b01 : 2'b00;
      b3.data_in  = (j <= 4) ? 8'(j) : 8'h00;
      step();
      if (j >= 3 && j <= 6) begin
        chk($sformatf("stream_data_%0d", j), 64'(b3.data_out), 64'(j - 2));
        chk($sformatf("stream_valid_%0d", j), 64'(b3.out_valid), 64'd1);
        chk($sformatf("stream_ctrl_%0d", j), 64'(b3.ctrl_out), 64'd1);
      end
    end
    chk("stream_retire", 64'(b3.retire_cnt), 64'd4);
    chk("stream_drained", 64'(b3.out_valid), 64'd0);
    chk("stream_stall_cnt", 64'(b3.stall_cnt), 64'd0);

    // Fill all three stages with ctrl=11, then flush and stall together
    for (int j = 0; j < 3; j++) begin
      b3.in_valid = 1; b3.ctrl_in = 2'b11; b3.data_in = 8'h10 + 8'(j);
      step();
    end
    chk("fill_data", 64'(b3.data_out), 64'h10);
    chk("fill_ctrl", 64'(b3.ctrl_out), 64'd3);
    b3.flush = 1; b3.stall = 1;
    step();
    chk("flush_valid", 64'(b3.out_valid), 64'd0);
    chk("flush_ctrl", 64'(b3.ctrl_out), 64'd0);
    chk("flush_stall_cnt", 64'(b3.stall_cnt), 64'd0);
    chk("flush_retire", 64'(b3.retire_cnt), 64'd5);
    chk("flush_data_kept", 64'(b3.data_out), 64'h10);
    b3.flush = 0; b3.stall = 0; b3.in_valid = 0; b3.ctrl_in = 0; b3.data_in = 0;
    step();
    chk("flush_all_valid", 64'(b3.out_valid), 64'd0);
    chk("flush_all_ctrl", 64'(b3.ctrl_out), 64'd0);
    chk("flush_all_data", 64'(b3.data_out), 64'h11);
    chk("flush_no_retire", 64'(b3.retire_cnt), 64'd5);

    // Mid-stream reset discards in-flight entries and counters
    b3.in_valid = 1; b3.ctrl_in = 2'b10; b3.data_in = 8'h33;
    step();
    step();
    step();
    chk("mid_pre_valid", 64'(b3.out_valid), 64'd1);
    rst = 1;
    step();
    rst = 0; b3.in_valid = 0; b3.ctrl_in = 0; b3.data_in = 0;
    chk("mid_rst_valid", 64'(b3.out_valid), 64'd0);
    chk("mid_rst_data", 64'(b3.data_out), 64'd0);
    chk("mid_rst_retire", 64'(b3.retire_cnt), 64'd0);

    // Stall on DEPTH=1 holding 0xA5 for three cycles
    b1.in_valid = 1; b1.ctrl_in = 2'b10; b1.data_in = 8'hA5;
    step();
    chk("d1_load", 64'(b1.data_out), 64'hA5);
    b1.stall = 1; b1.data_in = 8'h5A; b1.ctrl_in = 2'b01;
    for (int j = 0; j < 3; j++) begin
      step();
      chk($sformatf("stall_hold_%0d", j), 64'(b1.data_out), 64'hA5);
    end
    chk("stall_cnt3", 64'(b1.stall_cnt), 64'd3);
    chk("stall_retire", 64'(b1.retire_cnt), 64'd0);
    b1.stall = 0;
    step();
    chk("release_data", 64'(b1.data_out), 64'h5A);
    chk("release_ctrl", 64'(b1.ctrl_out), 64'd1);
    chk("release_retire", 64'(b1.retire_cnt), 64'd1);

    // Bubble gating: invalid input must not propagate control bits
    b1.in_valid = 0; b1.ctrl_in = 2'b11; b1.data_in = 8'h77;
    step();
    chk("bubble_valid", 64'(b1.out_valid), 64'd0);
    chk("bubble_ctrl", 64'(b1.ctrl_out), 64'd0);
    chk("bubble_data", 64'(b1.data_out), 64'h77);
    chk("bubble_retire", 64'(b1.retire_cnt), 64'd2);

    // 4-bit retire counter: 17 retirements wrap to 1
    bw.in_valid = 1; bw.ctrl_in = 2'b01;
    for (int j = 1; j <= 18; j++) begin
      if (j == 18) bw.in_valid = 0;
      bw.data_in = 8'(j);
      step();
      if (j == 16) chk("wrap_pre_f", 64'(bw.retire_cnt), 64'hF);
      if (j == 17) chk("wrap_zero", 64'(bw.retire_cnt), 64'h0);
    end
    chk("wrap_one", 64'(bw.retire_cnt), 64'd1);
    chk("wrap_stall_cnt", 64'(bw.stall_cnt), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
